piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage sitting directly upstream of the serial pattern detectors; it accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x.
- Provides a bit_valid qualifier and a last_bit marker so downstream framing logic can align to word boundaries.
- Idle line drives x=0, which the detectors treat as a neutral bit.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  parallel word; sampled only in the cycle where data_valid && data_ready
- data_valid  input  1  upstream word available
- data_ready  output  1  serializer can accept a word this cycle
- x  output  1  serial bit out, registered
- bit_valid  output  1  x carries a real data bit this cycle, registered
- last_bit  output  1  x is the final bit of the current word, registered

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high on port reset.
- Reset: state=IDLE, shift register=0, bit counter=0, x=0, bit_valid=0, last_bit=0. data_ready reads 1 while in IDLE after reset.
- Transfer: occurs on any rising edge where data_valid && data_ready. data_valid with data_ready=0 is ignored; no data is captured.
- data_ready is decoded from state and counter only, with no combinational path from data_valid. It equals 1 in IDLE, and 1 in SHIFT only when counter==WIDTH-1 (last bit on the line). Otherwise it is 0.
- State machine: IDLE and SHIFT.
  - IDLE, accept: load the shift register, counter<=0, go to SHIFT.
  - IDLE, no accept: stay in IDLE.
  - SHIFT, counter<WIDTH-1: shift, counter+1, stay in SHIFT.
  - SHIFT, counter==WIDTH-1 with accept: reload, counter<=0, stay in SHIFT. Back-to-back words have zero gap.
  - SHIFT, counter==WIDTH-1 without accept: go to IDLE.
- Latency: a word accepted at edge t has its first bit on x during cycle t+1 and its last bit during cycle t+WIDTH. bit_valid=1 for exactly WIDTH consecutive cycles per word.
- Bit order:
  - MSB_FIRST=1: x = shreg[WIDTH-1]; shift left, filling with 0.
  - MSB_FIRST=0: x = shreg[0]; shift right, filling with 0.
- last_bit=1 only together with bit_valid=1 and counter==WIDTH-1.
- In IDLE: x=0, bit_valid=0, last_bit=0.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1, so no wrap beyond that value.
- Reset mid-word: the word in flight is discarded immediately (asynchronous). The next cycle after reset release shows the IDLE outputs; no partial resumption.
- data_in changing outside the accept cycle has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_SHIFT (1-bit);
  - a clog2 function for counter width;
  - the default word width constant, shared with the detector stages.
- No sub-module; the counter and shift register are single-process logic inside the block.

Test Plan:
- Reset asserted mid-simulation -> x=0, bit_valid=0, last_bit=0 and data_ready=1 in the following cycle, with no clock edge required for outputs to clear.
- MSB_FIRST=1, accept 8'hD0 at edge t -> x = 1,1,0,1,0,0,0,0 in cycles t+1..t+8; bit_valid high for exactly those 8 cycles; last_bit high at t+8 only; data_ready low t+1..t+7 and high at t+8.
- Back-to-back, data_valid held high with 8'hD0 then 8'hA5 -> 16 contiguous valid bits 11010000 10100101; last_bit at bits 8 and 16; bit_valid never drops between words.
- MSB_FIRST=0, accept 8'h0B -> x = 1,1,0,1,0,0,0,0. This stream feeds a 1101 detector, which must flag on the 4th bit.
- data_valid pulsed while data_ready=0 (mid-word, counter=3) with 8'hFF -> pulse ignored; the current word completes unchanged, then the serializer returns to IDLE (x=0).
- Reset asserted during bit 4 of 8'hD0, released, then 8'h0F accepted -> no residual bits of 8'hD0 appear; output is exactly 0,0,0,0,1,1,1,1 with correct last_bit.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// rtl/piso_bit_serializer_pkg.sv - shared types and constants for the bit serializer
package piso_bit_serializer_pkg;

  // Word width shared with the downstream serial pattern detectors.
  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// rtl/piso_bit_serializer_if.sv - word handshake in, qualified serial bit stream out
interface piso_bit_serializer_if
  import piso_bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             x;
  logic             bit_valid;
  logic             last_bit;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  x,
    input  bit_valid,
    input  last_bit
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output x,
    output bit_valid,
    output last_bit
  );

endinterface

// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - parallel-in/serial-out stage feeding the serial detectors
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  piso_bit_serializer_if.slave  bus
);

  localparam int              CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             ready;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? (word << 1) : (word >> 1);
  endfunction

  // Ready depends only on registered state so upstream never sees a loop through data_valid.
  assign ready  = (state_q == ST_IDLE) || (cnt_q == CNT_LAST);
  assign accept = bus.data_valid && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          shreg_d = shift_once(shreg_q);
          cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
        end else begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are precomputed from next state so they leave dedicated flops.
    bit_valid_d = (state_d == ST_SHIFT);
    last_bit_d  = bit_valid_d && (cnt_d == CNT_LAST);
    x_d         = bit_valid_d && head_bit(shreg_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      x_q         <= x_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

  assign bus.data_ready = ready;
  assign bus.x          = x_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.last_bit   = last_bit_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - self-checking bench for both bit orders of the serializer
module tb_piso_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  piso_bit_serializer_if #(.WIDTH(W)) if_m ();
  piso_bit_serializer_if #(.WIDTH(W)) if_l ();

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (if_l)
  );

  int checks = 0;
  int errors = 0;

  // Reference: queue of bits still to appear on the line, {bit, last}; front is on x now.
  logic [1:0] qm[$];
  logic [1:0] ql[$];

  logic [31:0] hx_m, hv_m, hl_m, hx_l, hv_l, hl_l;

  typedef struct {
    logic       lsb;
    logic [7:0] data;
    logic [7:0] exp_seq;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] word_bit(input logic [W-1:0] w, input logic msb, input int i);
    int idx;
    idx = msb ? (W - 1 - i) : i;
    return {w[idx], (i == W - 1)};
  endfunction

  task automatic check_out(input string tag, input logic xv, input logic bv, input logic lb,
                           input logic rdy, input int sz, input logic [1:0] head);
    check({tag, ".x"}, {31'd0, xv}, {31'd0, (sz > 0) ? head[1] : 1'b0});
    check({tag, ".bit_valid"}, {31'd0, bv}, {31'd0, sz > 0});
    check({tag, ".last_bit"}, {31'd0, lb}, {31'd0, (sz > 0) ? head[0] : 1'b0});
    check({tag, ".data_ready"}, {31'd0, rdy}, {31'd0, sz <= 1});
  endtask

  task automatic cycle();
    logic acc_m, acc_l;
    logic [1:0] hm, hl;
    @(posedge clk);
    acc_m = if_m.data_valid && (qm.size() <= 1);
    acc_l = if_l.data_valid && (ql.size() <= 1);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (acc_m) for (int i = 0; i < W; i++) qm.push_back(word_bit(if_m.data_in, 1'b1, i));
    if (acc_l) for (int i = 0; i < W; i++) ql.push_back(word_bit(if_l.data_in, 1'b0, i));
    @(negedge clk);
    hm = (qm.size() > 0) ? qm[0] : 2'b00;
    hl = (ql.size() > 0) ? ql[0] : 2'b00;
    check_out("msb", if_m.x, if_m.bit_valid, if_m.last_bit, if_m.data_ready, qm.size(), hm);
    check_out("lsb", if_l.x, if_l.bit_valid, if_l.last_bit, if_l.data_ready, ql.size(), hl);
    hx_m = {hx_m[30:0], if_m.x};
    hv_m = {hv_m[30:0], if_m.bit_valid};
    hl_m = {hl_m[30:0], if_m.last_bit};
    hx_l = {hx_l[30:0], if_l.x};
    hv_l = {hv_l[30:0], if_l.bit_valid};
    hl_l = {hl_l[30:0], if_l.last_bit};
  endtask

  task automatic clear_hist();
    hx_m = '0; hv_m = '0; hl_m = '0;
    hx_l = '0; hv_l = '0; hl_l = '0;
  endtask

  // Asserted between edges: outputs must clear without any clock edge.
  task automatic async_reset(input string name);
    #2 reset = 1'b1;
    #1;
    check({name, ".msb_idle"}, {28'd0, if_m.x, if_m.bit_valid, if_m.last_bit, if_m.data_ready}, 32'h1);
    check({name, ".lsb_idle"}, {28'd0, if_l.x, if_l.bit_valid, if_l.last_bit, if_l.data_ready}, 32'h1);
    qm.delete();
    ql.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int det_pos;
    logic [3:0] window;

    vecs[0] = '{1'b0, 8'hD0, 8'hD0};
    vecs[1] = '{1'b0, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 8'h0F, 8'h0F};
    vecs[3] = '{1'b0, 8'h80, 8'h80};
    vecs[4] = '{1'b1, 8'h0B, 8'hD0};
    vecs[5] = '{1'b1, 8'h81, 8'h81};
    vecs[6] = '{1'b1, 8'h3C, 8'h3C};
    vecs[7] = '{1'b1, 8'h01, 8'h80};

    if_m.data_valid = 1'b0; if_m.data_in = '0;
    if_l.data_valid = 1'b0; if_l.data_in = '0;
    clear_hist();

    #1 reset = 1'b1;
    #1;
    check("reset.msb", {28'd0, if_m.x, if_m.bit_valid, if_m.last_bit, if_m.data_ready}, 32'h1);
    check("reset.lsb", {28'd0, if_l.x, if_l.bit_valid, if_l.last_bit, if_l.data_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    for (int v = 0; v < 8; v++) begin
      clear_hist();
      if (vecs[v].lsb) begin
        if_l.data_in = vecs[v].data; if_l.data_valid = 1'b1;
      end else begin
        if_m.data_in = vecs[v].data; if_m.data_valid = 1'b1;
      end
      cycle();
      if_m.data_valid = 1'b0; if_l.data_valid = 1'b0;
      if_m.data_in = 8'hFF; if_l.data_in = 8'hFF;
      repeat (8) cycle();
      if (vecs[v].lsb) begin
        check($sformatf("vec%0d.seq", v), {23'd0, hx_l[8:0]}, {23'd0, vecs[v].exp_seq, 1'b0});
        check($sformatf("vec%0d.valid", v), {23'd0, hv_l[8:0]}, 32'h1FE);
        check($sformatf("vec%0d.last", v), {23'd0, hl_l[8:0]}, 32'h002);
      end else begin
        check($sformatf("vec%0d.seq", v), {23'd0, hx_m[8:0]}, {23'd0, vecs[v].exp_seq, 1'b0});
        check($sformatf("vec%0d.valid", v), {23'd0, hv_m[8:0]}, 32'h1FE);
        check($sformatf("vec%0d.last", v), {23'd0, hl_m[8:0]}, 32'h002);
      end
    end

    // 0x0B sent LSB first must trip a 1101 detector on its 4th bit.
    clear_hist();
    if_l.data_in = 8'h0B; if_l.data_valid = 1'b1;
    cycle();
    if_l.data_valid = 1'b0;
    repeat (7) cycle();
    det_pos = 0;
    window = '0;
    for (int k = 0; k < 8; k++) begin
      window = {window[2:0], hx_l[7-k]};
      if (det_pos == 0 && window == 4'b1101) det_pos = k + 1;
    end
    check("lsb_0b.detect_pos", det_pos, 4);

    // Back-to-back words with data_valid held high.
    clear_hist();
    if_m.data_in = 8'hD0; if_m.data_valid = 1'b1;
    cycle();
    if_m.data_in = 8'hA5;
    repeat (8) cycle();
    if_m.data_valid = 1'b0;
    repeat (7) cycle();
    check("b2b.seq", {16'd0, hx_m[15:0]}, 32'hD0A5);
    check("b2b.valid", {16'd0, hv_m[15:0]}, 32'hFFFF);
    check("b2b.last", {16'd0, hl_m[15:0]}, 32'h0101);
    cycle();
    check("b2b.idle_x", {31'd0, if_m.x}, 32'd0);

    // data_valid pulse while busy (counter 3) must be ignored.
    clear_hist();
    if_m.data_in = 8'hD0; if_m.data_valid = 1'b1;
    cycle();
    if_m.data_valid = 1'b0;
    repeat (3) cycle();
    if_m.data_in = 8'hFF; if_m.data_valid = 1'b1;
    cycle();
    if_m.data_valid = 1'b0;
    repeat (4) cycle();
    check("pulse.seq", {23'd0, hx_m[8:0]}, 32'h1A0);
    check("pulse.valid", {23'd0, hv_m[8:0]}, 32'h1FE);
    check("pulse.ready_idle", {31'd0, if_m.data_ready}, 32'd1);

    // Reset during bit 4 of 0xD0, then 0x0F must come out clean.
    if_m.data_in = 8'hD0; if_m.data_valid = 1'b1;
    cycle();
    if_m.data_valid = 1'b0;
    repeat (3) cycle();
    async_reset("midword");
    clear_hist();
    cycle();
    if_m.data_in = 8'h0F; if_m.data_valid = 1'b1;
    cycle();
    if_m.data_valid = 1'b0;
    repeat (8) cycle();
    check("post_reset.seq", {22'd0, hx_m[9:0]}, 32'h01E);
    check("post_reset.valid", {22'd0, hv_m[9:0]}, 32'h1FE);
    check("post_reset.last", {22'd0, hl_m[9:0]}, 32'h002);

    // Randomized traffic on both orders against the queue model.
    for (int c = 0; c < 800; c++) begin
      if_m.data_valid = ($urandom_range(0, 3) != 0);
      if_m.data_in    = W'($urandom);
      if_l.data_valid = ($urandom_range(0, 2) != 0);
      if_l.data_in    = W'($urandom);
      if (c % 257 == 200) async_reset("random");
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
